// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: column drive, row synchronise, frame debounce, latched key + status.
// Optional auto-repeat while a key is held is enabled by defining KEYPAD_AUTOREPEAT_EN.
module keypad_scan #(
    parameter int unsigned SCAN_DIV      = 1000,
    parameter int unsigned DEBOUNCE      = 4,
    parameter int unsigned REPEAT_FRAMES = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    input  logic       ack,
    output logic [7:0] key_code,
    output logic [2:0] status
);

    localparam int unsigned SlotW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    if (SCAN_DIV < 4 || DEBOUNCE < 1 || DEBOUNCE > 15 || REPEAT_FRAMES < 1) begin : g_bad_param
        $error("keypad_scan: parameter out of range");
    end

    typedef enum logic [1:0] {StIdle, StPressDb, StHeld, StRelDb} state_e;

    state_e             state;
    logic [3:0]         rows_meta, rows_sync;
    logic [3:0]         hits;
    logic [SlotW-1:0]   slot_cnt;
    logic [1:0]         col;
    logic [15:0]        frame;
    logic [15:0]        frame_full;
    logic [3:0]         cnt, cnt_inc, cand;
    logic [3:0]         key_q;
    logic               valid, overrun, pressed;
    logic               slot_end, frame_end, deb_hit;
    logic               f_none, f_multi, f_single;
    logic [3:0]         f_key;
    logic               press_latch, rep_latch, latch;

    assign hits      = ~rows_sync;
    assign slot_end  = (slot_cnt == SlotW'(SCAN_DIV - 1));
    assign frame_end = slot_end && (col == 2'd3);
    assign cnt_inc   = cnt + 4'd1;
    // cnt is zero in IDLE and HELD, so this also covers the DEBOUNCE = 1 direct paths
    assign deb_hit   = (cnt_inc == 4'(DEBOUNCE));

    assign cols     = ~(4'b0001 << col);
    assign pressed  = (state == StHeld) || (state == StRelDb);
    assign key_code = {4'h0, key_q};
    assign status   = {overrun, pressed, valid};

    // Frame as it will be once the current column's hits are stored
    always_comb begin
        frame_full = frame;
        frame_full[{col, 2'b00} +: 4] = hits;
    end

    // Frame bit index is col*4 + row; key code is {row, col}
    always_comb begin
        f_none  = 1'b1;
        f_multi = 1'b0;
        f_key   = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (frame_full[i]) begin
                if (!f_none) f_multi = 1'b1;
                f_none = 1'b0;
                f_key  = {2'(i), 2'(i >> 2)};
            end
        end
        f_single = !f_none && !f_multi;
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    logic [15:0] rep_cnt, rep_inc;
    logic        rep_match;

    assign rep_inc   = rep_cnt + 16'd1;
    assign rep_match = f_single && (f_key == key_q);
    assign rep_latch = frame_end && (state == StHeld) && rep_match &&
                       (rep_inc == 16'(REPEAT_FRAMES));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rep_cnt <= '0;
        end else if (frame_end) begin
            // Any frame evaluated outside HELD means HELD is being (re)entered
            if (state != StHeld || !rep_match || rep_latch) rep_cnt <= '0;
            else                                           rep_cnt <= rep_inc;
        end
    end
`else
    assign rep_latch = 1'b0;
`endif

    assign press_latch = frame_end && f_single && deb_hit &&
                         ((state == StIdle) || (state == StPressDb && f_key == cand));
    assign latch       = press_latch || rep_latch;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rows_meta <= 4'hF;
            rows_sync <= 4'hF;
            slot_cnt  <= '0;
            col       <= 2'd0;
            frame     <= '0;
            state     <= StIdle;
            cnt       <= '0;
            cand      <= '0;
            key_q     <= '0;
            valid     <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rows_meta <= rows;
            rows_sync <= rows_meta;
            slot_cnt  <= slot_end ? '0 : slot_cnt + 1'b1;
            if (slot_end) begin
                frame[{col, 2'b00} +: 4] <= hits;
                col <= col + 2'd1;
            end

            if (frame_end) begin
                case (state)
                    StIdle: begin
                        if (f_single) begin
                            cand <= f_key;
                            if (deb_hit) state <= StHeld;
                            else begin
                                state <= StPressDb;
                                cnt   <= cnt_inc;
                            end
                        end
                    end
                    StPressDb: begin
                        if (f_single && f_key == cand) begin
                            if (deb_hit) begin
                                state <= StHeld;
                                cnt   <= '0;
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end else begin
                            state <= StIdle;
                            cnt   <= '0;
                        end
                    end
                    StHeld: begin
                        if (f_none) begin
                            if (deb_hit) state <= StIdle;
                            else begin
                                state <= StRelDb;
                                cnt   <= cnt_inc;
                            end
                        end
                    end
                    StRelDb: begin
                        if (f_none) begin
                            if (deb_hit) begin
                                state <= StIdle;
                                cnt   <= '0;
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end else begin
                            state <= StHeld;
                            cnt   <= '0;
                        end
                    end
                    default: begin
                        state <= StIdle;
                        cnt   <= '0;
                    end
                endcase
            end

            // A latch on the same edge as ack wins but still clears overrun
            if (latch) begin
                key_q   <= f_key;
                valid   <= 1'b1;
                overrun <= !ack && (overrun || valid);
            end else if (ack) begin
                valid   <= 1'b0;
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan: directed scenarios plus random frames checked against
// a frame-level behavioural model of the debounce, latch and acknowledge rules.
module tb_keypad_scan;

    localparam int unsigned SD  = 4;
    localparam int unsigned DEB = 3;
    localparam int unsigned REP = 2;
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam bit AUTOREP = 1'b1;
`else
    localparam bit AUTOREP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        ack;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic [7:0]  key_code;
    logic [2:0]  status;
    logic [15:0] keys;   // bit index = key code = row*4 + col

    int checks = 0;
    int errors = 0;

    // Frame-level model
    bit         m_held;
    int         m_run;
    int         m_cand;
    int         m_rep;
    logic [7:0] m_code;
    bit         m_valid;
    bit         m_ovr;

    int pool [5] = '{0, 5, 10, 15, 9};

    keypad_scan #(
        .SCAN_DIV      (SD),
        .DEBOUNCE      (DEB),
        .REPEAT_FRAMES (REP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rows     (rows),
        .cols     (cols),
        .ack      (ack),
        .key_code (key_code),
        .status   (status)
    );

    always #5 clk = ~clk;

    // Physical keypad: a pressed key pulls its row low while its column is driven
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4 + c] && !cols[c]) rows[r] = 1'b0;
    end

    function automatic logic [15:0] kbit(input int code);
        kbit = 16'h0001 << code;
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_held = 0; m_run = 0; m_cand = 0; m_rep = 0;
        m_code = 8'h00; m_valid = 0; m_ovr = 0;
    endtask

    task automatic model_frame(input logic [15:0] k, input bit ack_mid, input bit ack_end);
        int n;
        int idx;
        bit lat;
        n   = $countones(k);
        idx = 0;
        lat = 0;
        for (int i = 0; i < 16; i++) if (k[i]) idx = i;
        if (ack_mid) begin m_valid = 0; m_ovr = 0; end
        if (!m_held) begin
            if (n == 1) begin
                if (m_run == 0) begin m_run = 1; m_cand = idx; end
                else if (idx == m_cand) m_run++;
                else m_run = 0;
            end else begin
                m_run = 0;
            end
            if (m_run == DEB) begin
                lat = 1; m_held = 1; m_run = 0; m_rep = 0; m_code = 8'(m_cand);
            end
        end else begin
            if (n == 0) begin
                m_run++;
                if (m_run == DEB) begin m_held = 0; m_run = 0; end
            end else if (m_run > 0) begin
                m_run = 0; m_rep = 0;
            end else if (AUTOREP && n == 1 && idx == int'(m_code)) begin
                m_rep++;
                if (m_rep == REP) begin lat = 1; m_rep = 0; end
            end else begin
                m_rep = 0;
            end
        end
        if (lat) begin
            m_ovr   = ack_end ? 1'b0 : (m_ovr | m_valid);
            m_valid = 1;
        end else if (ack_end) begin
            m_valid = 0; m_ovr = 0;
        end
    endtask

    task automatic check_model();
        check("key_code", key_code, m_code);
        check("status", {5'b0, status}, {5'b0, m_ovr, m_held, m_valid});
    endtask

    // One full frame with keys held from its start; optional ack mid-frame or on the frame-end edge
    task automatic run_frame(input logic [15:0] k, input bit ack_mid, input bit ack_end);
        logic [3:0] ec;
        keys = k;
        for (int i = 1; i <= 16; i++) begin
            ack = (ack_mid && i == 8) || (ack_end && i == 16);
            @(posedge clk);
            #1;
            ack = 1'b0;
            if (i % 4 == 0) begin
                ec = ~(4'b0001 << ((i / 4) % 4));
                check("cols", {4'b0, cols}, {4'b0, ec});
            end
        end
        model_frame(k, ack_mid, ack_end);
        check_model();
    endtask

    initial begin
        int nlat;
        logic [15:0] k;
        logic [15:0] prev;
        int r;

        reset = 1'b1;
        ack   = 1'b0;
        keys  = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_cols", {4'b0, cols}, 8'h0E);
        check("rst_key", key_code, 8'h00);
        check("rst_status", {5'b0, status}, 8'h00);
        @(negedge clk);
        reset = 1'b0;

        // Clean press of row2/col1
        run_frame(kbit(9), 0, 0);
        run_frame(kbit(9), 0, 0);
        check("press_early", {5'b0, status}, 8'h00);
        run_frame(kbit(9), 0, 0);
        check("press_key", key_code, 8'h09);
        check("press_status", {5'b0, status}, 8'h03);
        run_frame(kbit(9), 1, 0);
        check("ack_status", {5'b0, status}, 8'h02);
        repeat (3) run_frame('0, 0, 0);
        check("release_status", {5'b0, status}, 8'h00);

        // Bounce
        for (int f = 0; f < 6; f++) run_frame((f % 2 == 0) ? kbit(5) : 16'h0, 0, 0);
        check("bounce_status", {5'b0, status}, 8'h00);

        // Overrun
        repeat (3) run_frame(kbit(5), 0, 0);
        repeat (3) run_frame('0, 0, 0);
        check("ovr_prev", {5'b0, status}, 8'h01);
        repeat (3) run_frame(kbit(10), 0, 0);
        check("ovr_key", key_code, 8'h0A);
        check("ovr_status", {5'b0, status}, 8'h07);
        run_frame(kbit(10), 1, 0);
        check("ovr_ack", {5'b0, status}, 8'h02);
        repeat (3) run_frame('0, 0, 0);
        // ack on the same edge as a latch while valid is already set
        repeat (3) run_frame(kbit(5), 0, 0);
        repeat (3) run_frame('0, 0, 0);
        repeat (2) run_frame(kbit(10), 0, 0);
        run_frame(kbit(10), 0, 1);
        check("same_edge_key", key_code, 8'h0A);
        check("same_edge_status", {5'b0, status}, 8'h03);
        repeat (3) run_frame('0, 1, 0);

        // Multi-key
        run_frame(kbit(0) | kbit(15), 1, 0);
        repeat (3) run_frame(kbit(0) | kbit(15), 0, 0);
        check("multi_status", {5'b0, status}, 8'h00);
        repeat (3) run_frame(kbit(0), 0, 0);
        check("multi_key", key_code, 8'h00);
        check("multi_status2", {5'b0, status}, 8'h03);
        repeat (3) run_frame('0, 1, 0);

        // Auto-repeat (or single latch when disabled)
        nlat = 0;
        for (int f = 0; f < 9; f++) begin
            run_frame(kbit(3), 1, 0);
            if (status[0]) nlat++;
        end
        check("repeat_latches", 8'(nlat), AUTOREP ? 8'd4 : 8'd1);
        check("repeat_key", key_code, 8'h03);
        repeat (3) run_frame('0, 1, 0);

        // Reset mid-slot after a latch
        repeat (3) run_frame(kbit(6), 0, 0);
        keys = kbit(6);
        repeat (6) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("mid_rst_cols", {4'b0, cols}, 8'h0E);
        check("mid_rst_key", key_code, 8'h00);
        check("mid_rst_status", {5'b0, status}, 8'h00);
        model_reset();
        keys = '0;
        @(negedge clk);
        reset = 1'b0;

        // Random frames against the model
        prev = '0;
        for (int f = 0; f < 150; f++) begin
            if ($urandom_range(0, 99) < 60) begin
                k = prev;
            end else begin
                r = $urandom_range(0, 9);
                if (r < 4)      k = '0;
                else if (r < 9) k = kbit(pool[$urandom_range(0, 4)]);
                else            k = kbit(pool[$urandom_range(0, 4)]) | kbit($urandom_range(0, 15));
            end
            prev = k;
            run_frame(k, $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Matrix-keypad scanner feeding the calculator's input ports. Drives a 4x4 keypad one column at a time, synchronises and debounces the row returns, and presents one latched key code with a status word. key_code connects to input port Pe0 and status to the 3-bit input port Pe1. The program polls status, reads the code, then acknowledges through an output-port strobe.

## Interface
- SCAN_DIV, 1000: clocks per column slot; must be ≥ 4.
- DEBOUNCE, 4: consecutive identical frames needed to accept a press or a release; range 1..15.
- REPEAT_FRAMES, 32: frames between auto-repeats; used only with KEYPAD_AUTOREPEAT_EN.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- rows  in  4  keypad row returns, active-low (pulled up); asynchronous to clk.
- cols  out  4  column drives, active-low, exactly one bit low at any time.
- ack  in  1  one-clock pulse from an output-port strobe; clears valid and overrun.
- key_code  out  8  latched key, {4'b0, row[1:0], col[1:0]} (0x00..0x0F).
- status  out  3  {overrun, pressed, valid}, to Pe1.

## Operation
- Synchroniser: rows passes through a 2-flop synchroniser and is inverted to active-high hit bits.
- Scan: a slot counter counts 0..SCAN_DIV-1. A column index counts 0..3 and wraps. cols = ~(4'b0001 << col).
- Slot end: the cycle with slot counter = SCAN_DIV-1. The synchronised hits are stored into frame bits [col*4 +: 4].
- Frame end: the slot end with col = 3. The completed frame (16 bits, including the current column) is evaluated on that edge.
- Frame classification: NONE (all zero), SINGLE (exactly one bit set), MULTI (two or more bits set).
- State machine, advancing only at frame end:
  - IDLE: a SINGLE frame → PRESS_DB with cnt = 1 and cand = that key. Any other frame stays in IDLE.
  - PRESS_DB: a SINGLE frame equal to cand increments cnt. When cnt reaches DEBOUNCE, latch the key and go to HELD. Any other frame → IDLE, cnt = 0.
  - HELD: a NONE frame → REL_DB with cnt = 1. Any other frame, including MULTI or a different key, stays in HELD.
  - REL_DB: a NONE frame increments cnt. When cnt reaches DEBOUNCE → IDLE. A non-NONE frame → HELD.
- When DEBOUNCE = 1, the first qualifying frame latches the key, or completes the release, directly.
- Latch: key_code ← cand and valid ← 1. If valid was already 1 and ack is not asserted in the same cycle, overrun ← 1 (sticky). key_code always holds the newest key.
- ack: clears valid and overrun. If ack and a latch occur on the same edge, the latch wins: valid = 1, overrun = 0.
- pressed = 1 in HELD and REL_DB; 0 otherwise.
- Reset: cols = 4'b1110, key_code = 8'h00, status = 3'b000, state IDLE, all counters and frame bits = 0. Reset mid-scan or mid-debounce discards everything.

## Timing
- Frame length = 4*SCAN_DIV clocks.
- A key that is stable before a frame starts is latched at the end of the DEBOUNCE-th frame. valid is visible in the following cycle.
- Synchroniser latency is 2 clocks. Row changes during the final 2 clocks of a slot may be missed in that slot.
- ack takes effect on the edge where it is sampled high. Holding ack high for several cycles is harmless.
- Status outputs are registered. No combinational path exists from rows or ack to any output.

## Configuration
- KEYPAD_AUTOREPEAT_EN defined:
  - A repeat counter runs in HELD and counts frames in which the frame is SINGLE and equal to key_code.
  - Every REPEAT_FRAMES such frames, a latch of the same code occurs, with the same valid/overrun rules.
  - The counter resets on entry to HELD and on any non-matching frame.
- KEYPAD_AUTOREPEAT_EN undefined: no repeat logic. Each press yields exactly one latch; REPEAT_FRAMES is ignored.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE=3, giving 16-clock frames.
- Reset: assert reset mid-slot → cols=1110, key_code=00, status=000 immediately. Release → cols steps 1110→1101→1011→0111 every 4 clocks.
- Clean press: hold row2/col1 from a frame start → valid=1 and key_code=0x09 after frame 3. pressed=1. Pulse ack → status=010. Release for 3 frames → status=000.
- Bounce: toggle the key every frame for 6 frames → valid stays 0 and state returns to IDLE each time.
- Overrun: press and release 0x05, then press 0x0A with no ack → key_code=0x0A, status=111. ack → status=010. Also drive ack on the same edge as a latch → status valid=1, overrun=0.
- Multi-key: hold 0x00 and 0x0F together → no latch. Release 0x0F → 0x00 latched 3 frames later.
- Autorepeat: with the macro defined and REPEAT_FRAMES=2, hold 0x03 and pulse ack after each latch → a new latch every 2 frames. With the macro undefined → exactly one latch.
